imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at a programmable base. Holds the program counter in reset (`cpu_hold`) until the image is loaded, then releases it. Sits between the external load source and the instruction memory's write port, opposite the PC/fetch read path.

## Interface

Parameters:
- `AW`, default 8: instruction-memory address width. Depth is 2**AW.
- `DW`, default 8: instruction word width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: load request; sampled only in IDLE.
- `base_addr`, in, AW: first write address; captured on accepted `start`.
- `len`, in, AW+1: number of words to load. 0 is legal. Values above 2**AW saturate to 2**AW.
- `in_valid`, in, 1: source has a word on `in_data`.
- `in_data`, in, DW: instruction word.
- `in_ready`, out, 1: loader accepts a word this cycle.
- `mem_we`, out, 1: instruction-memory write enable, registered.
- `mem_addr`, out, AW: write address, registered.
- `mem_wdata`, out, DW: write data, registered.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: single-cycle completion pulse, registered.
- `cpu_hold`, out, 1: holds PC/fetch in reset while high, registered.

## Operation

- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `cpu_hold`=1. State is IDLE.
- States are IDLE, LOAD and FIN.
- IDLE with `start`=1:
  - Capture `base_addr` into the address counter and saturated `len` into the remaining counter.
  - Set `cpu_hold`=1.
  - Go to FIN if `len`==0, else go to LOAD.
- LOAD:
  - `in_ready`=1, decoded from the state register only.
  - A beat is accepted when `in_valid` and `in_ready` are both 1 at an edge.
  - On that edge: `mem_we`<=1, `mem_addr`<=address counter, `mem_wdata`<=`in_data`. The address counter increments modulo 2**AW and the remaining counter decrements.
  - When the beat accepted has remaining==1, go to FIN.
  - With no beat, `mem_we`<=0.
- FIN: lasts one cycle. `in_ready`=0. On exit edge: `done`<=1, `cpu_hold`<=0, `mem_we`<=0, go to IDLE.
- `done` is 0 on every other edge.
- `start` in LOAD or FIN is ignored.
- Back-to-back loads are allowed: `start` may be high in the IDLE cycle right after FIN.
- Address wrap: writes past 2**AW-1 continue at 0. No error is raised.
- Memory contents are not this block's concern. Words already written are not rolled back on reset.

## Timing

- Write latency: `mem_we`/`mem_addr`/`mem_wdata` are valid in the cycle after the accepting edge.
- Throughput is one word per cycle with `in_valid` held high.
- Last beat accepted at edge E:
  - Final `mem_we`=1 during cycle E..E+1.
  - `done`=1 and `cpu_hold`=0 from edge E+1 for exactly one cycle (`done`).
  - `in_ready`=0 from edge E.
- `len`=0 with start at edge S: FIN after S, `done` pulses from S+1, no `mem_we`.
- `rst` low at any time, including mid-LOAD:
  - Outputs go to reset values immediately, without waiting for a clock.
  - State becomes IDLE, and a partial load is abandoned.
  - Operation resumes on the first edge after `rst` returns high.
- `in_data` is don't-care when `in_ready`=0 or `in_valid`=0.

## Test plan

- Reset: drive `rst`=0 mid-simulation with random inputs. Required: all outputs at reset values with no clock edge, `cpu_hold`=1, `busy`=0.
- Continuous load: `base_addr`=0x10, `len`=4, data 0xA1..0xA4 with `in_valid` always high. Required:
  - Writes (0x10,A1), (0x11,A2), (0x12,A3), (0x13,A4) on four consecutive cycles, each one cycle after its accept.
  - `done` pulses one cycle after the last write, and `cpu_hold` falls on the same edge.
- Bubbles: `len`=3, `in_valid` pattern 1,0,0,1,0,1, data 0x11,0x22,0x33. Required: exactly three `mem_we` cycles at consecutive addresses and no write in bubble cycles.
- Wrap: `base_addr`=0xFE, `len`=4. Required: write addresses FE, FF, 00, 01.
- Zero length and ignored start:
  - `len`=0 gives no `mem_we` and `done` one cycle after FIN.
  - A second `start` with `base_addr`=0x80, pulsed mid-LOAD, changes neither the addresses nor the count.
- Reset mid-load: `len`=5, assert `rst` after 2 accepted beats. Required:
  - Immediate reset values, `cpu_hold`=1.
  - After release, `base_addr`=0x20, `len`=1 writes (0x20,data) and pulses `done`.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes instruction words over a valid/ready stream and writes them to
// consecutive addresses starting at a programmable base. The CPU is held
// in reset through cpu_hold until the image is in place.
module imem_loader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Largest meaningful word count: the whole memory.
  localparam logic [AW:0]   MAX_LEN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;       // next address to be written
  logic [AW:0]   rem_reg, rem_next;         // words still expected
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic          done_reg, done_next;
  logic          cpu_hold_reg, cpu_hold_next;

  logic [AW:0]   len_sat;
  logic          len_zero;
  logic          beat;

  // Requests longer than the memory are clipped to one full pass.
  assign len_sat  = (len > MAX_LEN) ? MAX_LEN : len;
  assign len_zero = (len == '0);

  // Ready depends on the state register only, never on in_valid.
  assign in_ready = (state_reg == LOAD);
  assign beat     = in_valid && in_ready;
  assign busy     = (state_reg != IDLE);

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign done      = done_reg;
  assign cpu_hold  = cpu_hold_reg;

  // Next-state and datapath decode; done and mem_we default to a one-cycle pulse.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    rem_next       = rem_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    done_next      = 1'b0;
    cpu_hold_next  = cpu_hold_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next     = base_addr;
          rem_next      = len_sat;
          cpu_hold_next = 1'b1;
          state_next    = len_zero ? FIN : LOAD;
        end
      end

      LOAD: begin
        if (beat) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = addr_reg;
          mem_wdata_next = in_data;
          // Address wraps naturally at the top of memory.
          addr_next      = addr_reg + ADDR_ONE;
          rem_next       = rem_reg - REM_ONE;
          if (rem_reg == REM_ONE) begin
            state_next = FIN;
          end
        end
      end

      FIN: begin
        done_next     = 1'b1;
        cpu_hold_next = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Internal counters for address and remaining words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg <= '0;
      rem_reg  <= '0;
    end else begin
      addr_reg <= addr_next;
      rem_reg  <= rem_next;
    end
  end

  // Registered memory write port and status outputs; CPU stays held from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_reg      <= 1'b0;
      cpu_hold_reg  <= 1'b1;
    end else begin
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      done_reg      <= done_next;
      cpu_hold_reg  <= cpu_hold_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario-driven bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          cpu_hold;

  imem_loader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_exp;
  logic [AW-1:0] m_addr = '0;
  int            m_rem = 0;

  // Write monitor: every mem_we cycle must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mem_addr !== mon_exp.addr || mem_wdata !== mon_exp.data) begin
          miscompares++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_exp.addr, mon_exp.data);
        end else begin
          $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
        end
      end
    end
  end

  // Pulse start for one edge and load the reference model.
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    len = (AW+1)'($urandom);
    m_addr = b;
    m_rem = (l > 9'd256) ? 256 : int'(l);
  endtask

  // Present one cycle of stimulus; acc tells whether the model expects acceptance.
  task automatic beat(input logic v, input logic [DW-1:0] d, output logic acc);
    in_valid = v;
    in_data = d;
    acc = v && (m_rem > 0);
    if (acc) begin
      exp_q.push_back({m_addr, d});
      m_addr = m_addr + 8'd1;
      m_rem--;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = DW'($urandom);
  endtask

  task automatic test_reset();
    logic [AW+DW+4:0] got;
    logic [AW+DW+4:0] exp;
    in_valid = 1'b1; start = 1'b1; in_data = DW'($urandom); base_addr = AW'($urandom);
    #3 rst = 1'b0;
    #1;
    exp = {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b1};
    got = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_async: got %h, required %h", got, exp);
    end else $display("reset_async ok");
    repeat (2) @(posedge clk);
    #1;
    got = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_held: got %h, required %h", got, exp);
    end else $display("reset_held ok");
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    m_rem = 0;
  endtask

  task automatic test_continuous();
    logic acc;
    do_start(8'h10, 9'd4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
        miscompares++;
        $display("FAIL cont_ready beat %0d: in_ready=%b busy=%b cpu_hold=%b, required 1 1 1", i, in_ready, busy, cpu_hold);
      end
      beat(1'b1, 8'hA1 + 8'(i), acc);
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL cont_latency beat %0d: mem_we=%b addr=%h, required 1 %h", i, mem_we, mem_addr, 8'h10 + 8'(i));
      end else $display("cont beat %0d accepted", i);
    end
    vectors++;
    if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_fin: in_ready=%b done=%b busy=%b cpu_hold=%b, required 0 0 1 1", in_ready, done, busy, cpu_hold);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_done: done=%b cpu_hold=%b mem_we=%b, required 1 0 0", done, cpu_hold, mem_we);
    end else $display("cont done pulse ok");
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_idle: done=%b busy=%b cpu_hold=%b, required 0 0 0", done, busy, cpu_hold);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL cont_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_bubbles();
    logic          acc;
    logic          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] dat[3] = '{8'h11, 8'h22, 8'h33};
    int            k = 0;
    int            we_count = 0;
    do_start(8'h40, 9'd3);
    for (int i = 0; i < 6; i++) begin
      beat(pat[i], pat[i] ? dat[k] : 8'hEE, acc);
      if (pat[i]) k++;
      if (mem_we === 1'b1) we_count++;
      vectors++;
      if (mem_we !== acc) begin
        miscompares++;
        $display("FAIL bubble_we cycle %0d: mem_we=%b, required %b", i, mem_we, acc);
      end else $display("bubble cycle %0d mem_we=%b ok", i, mem_we);
    end
    @(posedge clk); #1;
    vectors++;
    if (we_count != 3 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_done: writes=%0d done=%b cpu_hold=%b, required 3 1 0", we_count, done, cpu_hold);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic          acc;
    logic [AW-1:0] wrap_addr[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_start(8'hFE, 9'd4);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 8'hC0 + 8'(i), acc);
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== wrap_addr[i]) begin
        miscompares++;
        $display("FAIL wrap_addr beat %0d: mem_we=%b addr=%h, required 1 %h", i, mem_we, mem_addr, wrap_addr[i]);
      end else $display("wrap beat %0d addr=%h ok", i, mem_addr);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_done: done=%b cpu_hold=%b, required 1 0", done, cpu_hold);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    do_start(8'h40, 9'd0);
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_fin: busy=%b in_ready=%b mem_we=%b done=%b cpu_hold=%b, required 1 0 0 0 1",
               busy, in_ready, mem_we, done, cpu_hold);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b cpu_hold=%b mem_we=%b busy=%b, required 1 0 0 0", done, cpu_hold, mem_we, busy);
    end else $display("zero length done ok");
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_ignored_start();
    logic acc;
    do_start(8'h30, 9'd3);
    beat(1'b1, 8'h71, acc);
    start = 1'b1; base_addr = 8'h80; len = 9'd1;
    beat(1'b1, 8'h72, acc);
    start = 1'b0;
    vectors++;
    if (mem_addr !== 8'h31 || busy !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_mid: addr=%h busy=%b in_ready=%b, required 31 1 1", mem_addr, busy, in_ready);
    end
    beat(1'b1, 8'h73, acc);
    vectors++;
    if (mem_addr !== 8'h32 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_last: addr=%h in_ready=%b, required 32 0", mem_addr, in_ready);
    end else $display("ignored start ok");
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_done: done=%b, required 1", done);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ign_idle: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    do_start(8'h50, 9'd2);
    beat(1'b1, 8'h01, acc);
    beat(1'b1, 8'h02, acc);
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_done: done=%b busy=%b, required 1 0", done, busy);
    end
    do_start(8'h60, 9'd2);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: done=%b busy=%b cpu_hold=%b in_ready=%b, required 0 1 1 1", done, busy, cpu_hold, in_ready);
    end else $display("back-to-back restart ok");
    beat(1'b1, 8'h03, acc);
    beat(1'b1, 8'h04, acc);
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second_done: done=%b cpu_hold=%b, required 1 0", done, cpu_hold);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    logic acc;
    do_start(8'h00, 9'h1FF);
    for (int i = 0; i < 256; i++) begin
      beat(1'b1, 8'(i * 3), acc);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_fin: in_ready=%b busy=%b, required 0 1", in_ready, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sat_done: done=%b pending=%0d, required 1 0", done, exp_q.size());
    end else $display("saturated length done ok");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    logic             acc;
    logic [AW+DW+4:0] got;
    logic [AW+DW+4:0] exp;
    do_start(8'h70, 9'd5);
    beat(1'b1, 8'h5A, acc);
    beat(1'b1, 8'h5B, acc);
    #2;
    exp_q.delete();
    m_rem = 0;
    in_valid = 1'b1; in_data = DW'($urandom); start = 1'b1;
    rst = 1'b0;
    #1;
    exp = {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b1};
    got = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midload_reset: got %h, required %h", got, exp);
    end else $display("mid-load reset ok");
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_resume: busy=%b cpu_hold=%b mem_we=%b, required 0 1 0", busy, cpu_hold, mem_we);
    end
    do_start(8'h20, 9'd1);
    beat(1'b1, 8'h99, acc);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h99) begin
      miscompares++;
      $display("FAIL midload_reload: mem_we=%b addr=%h data=%h, required 1 20 99", mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_done: done=%b cpu_hold=%b, required 1 0", done, cpu_hold);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_back_to_back();
    test_saturate();
    test_reset_mid_load();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
